// File: rtl/window_generator_pkg.sv
// Shared definitions for the 3x3 window generator: border codes, FSM states
// and the centre-position to border-code mapping.
package window_generator_pkg;

  localparam logic [3:0] CT_INIT     = 4'd0;
  localparam logic [3:0] CT_START    = 4'd1;
  localparam logic [3:0] CT_RSTART   = 4'd2;
  localparam logic [3:0] CT_LEFT     = 4'd3;
  localparam logic [3:0] CT_RIGHT    = 4'd4;
  localparam logic [3:0] CT_LEFTEND  = 4'd5;
  localparam logic [3:0] CT_RIGHTEND = 4'd6;
  localparam logic [3:0] CT_FULL     = 4'd8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Interior columns are CT_FULL on every row, including the first and last.
  function automatic logic [3:0] corner_code(input logic row_first, input logic row_last,
                                             input logic col_first, input logic col_last);
    if (col_first) return row_first ? CT_START  : (row_last ? CT_LEFTEND  : CT_LEFT);
    if (col_last)  return row_first ? CT_RSTART : (row_last ? CT_RIGHTEND : CT_RIGHT);
    return CT_FULL;
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel-in / window-out bundle of the window generator.
// WINDOW_GEN_SOF_EN adds the in_sof input and the frame_err output.
interface window_generator_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] line0_data0, line0_data1, line0_data2;
  logic [DATA_WIDTH-1:0] line1_data0, line1_data1, line1_data2;
  logic [DATA_WIDTH-1:0] line2_data0, line2_data1, line2_data2;
  logic [3:0]            corner_type;
  logic                  out_valid;
`ifdef WINDOW_GEN_SOF_EN
  logic                  in_sof;
  logic                  frame_err;

  modport master (
    output in_data, in_valid, in_sof,
    input  in_ready, corner_type, out_valid, frame_err,
    input  line0_data0, line0_data1, line0_data2,
    input  line1_data0, line1_data1, line1_data2,
    input  line2_data0, line2_data1, line2_data2
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output in_ready, corner_type, out_valid, frame_err,
    output line0_data0, line0_data1, line0_data2,
    output line1_data0, line1_data1, line1_data2,
    output line2_data0, line2_data1, line2_data2
  );
`else
  modport master (
    output in_data, in_valid,
    input  in_ready, corner_type, out_valid,
    input  line0_data0, line0_data1, line0_data2,
    input  line1_data0, line1_data1, line1_data2,
    input  line2_data0, line2_data1, line2_data2
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, corner_type, out_valid,
    output line0_data0, line0_data1, line0_data2,
    output line1_data0, line1_data1, line1_data2,
    output line2_data0, line2_data1, line2_data2
  );
`endif
endinterface

// File: rtl/window_generator_line_buffer.sv
// Single-port line memory: registered read, read-before-write on the same address.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/window_generator.sv
// Streaming 3x3 window generator: two line buffers, zero bubbles and a zero pad row.
// Optional start-of-frame resync enabled by defining WINDOW_GEN_SOF_EN.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input logic               clk,
  input logic               rst,
  window_generator_if.slave io_win
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_BUB  = XW'(IMG_W);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PAD  = YW'(IMG_H);

  state_t                r_state, w_state_nxt;
  logic [XW-1:0]         r_x, w_x_nxt, w_col_x;
  logic [YW-1:0]         r_y, w_y_nxt, w_col_y;
  logic                  w_col_v, w_col_lb, w_restart, w_in_ready;
  logic [DATA_WIDTH-1:0] w_col_pix;
`ifdef WINDOW_GEN_SOF_EN
  logic                  w_ferr, r_frame_err;
`endif

  // Stage 1 waits on the lb1 read, stage 2 on the lb0 read.
  logic                  r_s1_v, r_s1_lb, r_s2_v, r_s2_lb;
  logic [DATA_WIDTH-1:0] r_s1_pix, r_s2_pix, r_s2_lb1;
  logic [XW-1:0]         r_s1_x, r_s2_x;
  logic [YW-1:0]         r_s1_y, r_s2_y;
  logic [DATA_WIDTH-1:0] w_lb1_q, w_lb0_q;

  logic [2:0][DATA_WIDTH-1:0]      w_col;
  logic [2:0][2:0][DATA_WIDTH-1:0] r_win;
  logic                            r_out_valid;
  logic [3:0]                      r_corner;

  // state  | meaning
  // RUN    | accept pixels, one column per accepted pixel
  // BUBBLE | one zero column closing a row (x = IMG_W)
  // FLUSH  | zero pad row (x = 0..IMG_W-1) plus its bubble, then wrap to (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_col_x     = r_x;
    w_col_y     = r_y;
    w_col_v     = 1'b0;
    w_col_lb    = 1'b0;
    w_col_pix   = '0;
    w_in_ready  = 1'b0;
    w_restart   = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    w_ferr      = 1'b0;
`endif
    case (r_state)
      RUN: begin
        w_in_ready = 1'b1;
        if (io_win.in_valid) begin
          w_col_v   = 1'b1;
          w_col_lb  = 1'b1;
          w_col_pix = io_win.in_data;
`ifdef WINDOW_GEN_SOF_EN
          if (io_win.in_sof && (r_x != '0 || r_y != '0)) begin
            w_restart = 1'b1;
            w_ferr    = 1'b1;
            w_col_x   = '0;
            w_col_y   = '0;
          end else if (!io_win.in_sof && r_x == '0 && r_y == '0) begin
            w_ferr = 1'b1;
          end
`endif
          w_x_nxt = w_col_x + X_ONE;
          w_y_nxt = w_col_y;
          if (w_col_x == X_LAST) w_state_nxt = BUBBLE;
        end
      end
      BUBBLE: begin
        w_col_v     = 1'b1;
        w_x_nxt     = '0;
        w_y_nxt     = r_y + Y_ONE;
        w_state_nxt = (r_y == Y_LAST) ? FLUSH : RUN;
      end
      FLUSH: begin
        w_col_v = 1'b1;
        if (r_x == X_BUB) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = RUN;
        end else begin
          w_col_lb = 1'b1;
          w_x_nxt  = r_x + X_ONE;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // lb1 holds the previous row; its displaced value is written into lb0 a cycle later.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(AW)) u_lb1 (
    .clk     (clk),
    .i_en    (w_col_v & w_col_lb),
    .i_we    (w_col_v & w_col_lb),
    .i_addr  (w_col_x[AW-1:0]),
    .i_wdata (w_col_pix),
    .o_rdata (w_lb1_q)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(AW)) u_lb0 (
    .clk     (clk),
    .i_en    (r_s1_v & r_s1_lb),
    .i_we    (r_s1_v & r_s1_lb),
    .i_addr  (r_s1_x[AW-1:0]),
    .i_wdata (w_lb1_q),
    .o_rdata (w_lb0_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_lb  <= 1'b0;
      r_s1_pix <= '0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s2_v   <= 1'b0;
      r_s2_lb  <= 1'b0;
      r_s2_pix <= '0;
      r_s2_lb1 <= '0;
      r_s2_x   <= '0;
      r_s2_y   <= '0;
    end else begin
      r_s1_v   <= w_col_v;
      r_s1_lb  <= w_col_lb;
      r_s1_pix <= w_col_pix;
      r_s1_x   <= w_col_x;
      r_s1_y   <= w_col_y;
      r_s2_v   <= r_s1_v & ~w_restart;
      r_s2_lb  <= r_s1_lb;
      r_s2_pix <= r_s1_pix;
      r_s2_lb1 <= w_lb1_q;
      r_s2_x   <= r_s1_x;
      r_s2_y   <= r_s1_y;
    end
  end

  // Row 1 columns carry centre row 0, so their top tap is masked at entry.
  always_comb begin
    w_col = '0;
    if (r_s2_lb) begin
      w_col[0] = r_s2_pix;
      w_col[1] = r_s2_lb1;
      w_col[2] = (r_s2_y == Y_ONE) ? '0 : w_lb0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_win       <= '0;
      r_out_valid <= 1'b0;
      r_corner    <= CT_INIT;
    end else if (r_s2_v) begin
      for (int l = 0; l < 3; l++) begin
        r_win[l][2] <= r_win[l][1];
        r_win[l][1] <= r_win[l][0];
        r_win[l][0] <= w_col[l];
      end
      r_out_valid <= (r_s2_x != '0) && (r_s2_y != '0);
      r_corner    <= ((r_s2_x != '0) && (r_s2_y != '0)) ?
                     corner_code(r_s2_y == Y_ONE, r_s2_y == Y_PAD,
                                 r_s2_x == X_ONE, r_s2_x == X_BUB) : CT_INIT;
    end else begin
      r_out_valid <= 1'b0;
      r_corner    <= CT_INIT;
    end
  end

`ifdef WINDOW_GEN_SOF_EN
  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_ferr;
  end

  assign io_win.frame_err = r_frame_err;
`endif

  assign io_win.in_ready    = w_in_ready;
  assign io_win.out_valid   = r_out_valid;
  assign io_win.corner_type = r_corner;
  assign io_win.line0_data0 = r_win[0][0];
  assign io_win.line0_data1 = r_win[0][1];
  assign io_win.line0_data2 = r_win[0][2];
  assign io_win.line1_data0 = r_win[1][0];
  assign io_win.line1_data1 = r_win[1][1];
  assign io_win.line1_data2 = r_win[1][2];
  assign io_win.line2_data0 = r_win[2][0];
  assign io_win.line2_data1 = r_win[2][1];
  assign io_win.line2_data2 = r_win[2][2];

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator on a 4x3 frame with pixel (r,c) = 4r+c+1.
// Also exercises the start-of-frame resync when WINDOW_GEN_SOF_EN is defined.
module tb_window_generator;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ferr_cnt = 0;

  typedef struct packed {
    logic [3:0]           ct;
    logic [2:0][2:0][7:0] tap;
  } win_t;

  win_t wq[$];
  win_t mon_w;

  window_generator_if #(.DATA_WIDTH(8)) bus ();

  window_generator #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_win (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      mon_w.ct        = bus.corner_type;
      mon_w.tap[0][0] = bus.line0_data0;
      mon_w.tap[0][1] = bus.line0_data1;
      mon_w.tap[0][2] = bus.line0_data2;
      mon_w.tap[1][0] = bus.line1_data0;
      mon_w.tap[1][1] = bus.line1_data1;
      mon_w.tap[1][2] = bus.line1_data2;
      mon_w.tap[2][0] = bus.line2_data0;
      mon_w.tap[2][1] = bus.line2_data1;
      mon_w.tap[2][2] = bus.line2_data2;
      wq.push_back(mon_w);
    end
`ifdef WINDOW_GEN_SOF_EN
    if (!rst && bus.frame_err) ferr_cnt++;
`endif
  end

  // line l covers row r+1-l, tap t covers column c+1-t; outside the frame reads zero
  function automatic int exp_tap(input int l, input int t, input int r, input int c);
    int rr;
    int cc;
    rr = r + 1 - l;
    cc = c + 1 - t;
    if (rr < 0 || rr > 2 || cc < 0 || cc > 3) return 0;
    return 4 * rr + cc + 1;
  endfunction

  function automatic int exp_ct(input int r, input int c);
    if (c == 0) return (r == 0) ? 1 : ((r == 2) ? 5 : 3);
    if (c == 3) return (r == 0) ? 2 : ((r == 2) ? 6 : 4);
    return 8;
  endfunction

  task automatic drive_px(input logic [7:0] d, input logic sof, input int gap_pct);
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef WINDOW_GEN_SOF_EN
    bus.in_sof   = sof;
`endif
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk($sformatf("ready_wait_sof%0d", sof), 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    bus.in_sof   = 1'b0;
`endif
  endtask

  task automatic send_frame(input int npx, input int gap_pct);
    for (int i = 0; i < npx; i++) drive_px(8'(i + 1), i == 0, gap_pct);
  endtask

  task automatic check_windows(input string tag, input int nfr);
    int r;
    int c;
    chk({tag, "_count"}, 32'(wq.size()), 32'(12 * nfr));
    for (int i = 0; i < wq.size() && i < 12 * nfr; i++) begin
      r = (i % 12) / 4;
      c = i % 4;
      chk($sformatf("%s_%0d_r%0dc%0d_ct", tag, i, r, c), 32'(wq[i].ct), 32'(exp_ct(r, c)));
      for (int l = 0; l < 3; l++)
        for (int t = 0; t < 3; t++)
          chk($sformatf("%s_%0d_r%0dc%0d_l%0dd%0d", tag, i, r, c, l, t),
              32'(wq[i].tap[l][t]), 32'(exp_tap(l, t, r, c)));
    end
    wq.delete();
  endtask

  // Hand-computed centres (0,0), (1,1) and (2,3), indexed [line][data].
  task automatic check_golden();
    int e00[3][3] = '{'{6, 5, 0}, '{2, 1, 0}, '{0, 0, 0}};
    int e11[3][3] = '{'{11, 10, 9}, '{7, 6, 5}, '{3, 2, 1}};
    int e23[3][3] = '{'{0, 0, 0}, '{0, 12, 11}, '{0, 8, 7}};
    if (wq.size() < 12) return;
    chk("gold_c00_ct", 32'(wq[0].ct), 1);
    chk("gold_c11_ct", 32'(wq[5].ct), 8);
    chk("gold_c23_ct", 32'(wq[11].ct), 6);
    for (int l = 0; l < 3; l++)
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("gold_c00_l%0dd%0d", l, t), 32'(wq[0].tap[l][t]), 32'(e00[l][t]));
        chk($sformatf("gold_c11_l%0dd%0d", l, t), 32'(wq[5].tap[l][t]), 32'(e11[l][t]));
        chk($sformatf("gold_c23_l%0dd%0d", l, t), 32'(wq[11].tap[l][t]), 32'(e23[l][t]));
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef WINDOW_GEN_SOF_EN
    bus.in_sof   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_corner", 32'(bus.corner_type), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b0;

    // Clean frame with continuous in_valid: ready drops at 5, 10, 15 and 16-20.
    fork
      send_frame(12, 0);
      for (int k = 1; k <= 21; k++) begin
        @(negedge clk);
        chk($sformatf("ready_cyc%0d", k), 32'(bus.in_ready),
            (k == 5 || k == 10 || (k >= 15 && k <= 20)) ? 0 : 1);
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check_golden();
    check_windows("clean", 1);

    // Two back-to-back frames with ~50% input gaps.
    send_frame(12, 50);
    send_frame(12, 50);
    repeat (15) @(posedge clk);
    #1;
    if (wq.size() > 12) begin
      chk("b2b_c00_l2d0", 32'(wq[12].tap[2][0]), 0);
      chk("b2b_c00_l2d1", 32'(wq[12].tap[2][1]), 0);
    end
    check_windows("gaps", 2);

    // Reset in the middle of row 1, then a fresh frame.
    send_frame(6, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_corner", 32'(bus.corner_type), 0);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    wq.delete();
    send_frame(12, 0);
    repeat (15) @(posedge clk);
    #1;
    check_windows("afterrst", 1);

`ifdef WINDOW_GEN_SOF_EN
    chk("sof_no_err", 32'(ferr_cnt), 0);
    send_frame(6, 0);
    send_frame(12, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("sof_err_pulses", 32'(ferr_cnt), 1);
    check_windows("sof", 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
